// File: rtl/sum_seg_display.sv
// Purpose : captures the adder result {cout,s} on load, converts it to two BCD digits
//           with a 5-step sequential double-dabble, and scans them onto a 2-digit 7-seg display.
// Latency : busy for 5 cycles after an accepted load; new digits reach seg/an one cycle after busy falls.
// Backpressure: load is ignored (not queued) while busy is high.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   s[3:0], cout  : adder sum and carry-out, captured together as a 5-bit value
//   load          : capture strobe, honoured only while busy is low
//   busy          : conversion in progress
//   seg[6:0]      : segments {g,f,e,d,c,b,a}, active-low
//   dp            : decimal point (carry indicator on the ones digit), active-low
//   an[1:0]       : digit enables, active-low; an[0] = ones, an[1] = tens
module sum_seg_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] s,
    input  logic       cout,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int RW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        CONV  = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t state, state_nx;

    // conversion datapath
    logic [4:0] val_sh;     // captured value, shifted out MSB-first
    logic [7:0] bcd;        // {tens nibble, ones nibble}
    logic [7:0] bcd_adj;
    logic [7:0] bcd_nx;
    logic [2:0] step;
    logic       cf;
    logic       capture;
    logic       finish;

    // display registers
    logic [1:0] tens_r;
    logic [3:0] ones_r;
    logic       has_res;

    // scan
    logic [RW-1:0] rcnt;
    logic          sel;

    // next output values
    logic [6:0] seg_nx;
    logic [1:0] an_nx;
    logic       dp_nx;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    assign busy = (state == CONV);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BLANK;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        finish   = 1'b0;
        case (state)
            BLANK, SHOW: begin
                if (load) begin
                    capture  = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV: begin
                // step counts completed steps; the fifth step is taken while it reads 4
                if (step == 3'd4) begin
                    finish   = 1'b1;
                    state_nx = SHOW;
                end
            end
            default: state_nx = BLANK;
        endcase
    end

    // ---------------- double-dabble step ----------------
    // The tens nibble can never reach 5 for a 5-bit input, so its adjust is
    // kept only to make the step a faithful add-3-then-shift.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        bcd_nx = {bcd_adj[6:0], val_sh[4]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_sh  <= '0;
            bcd     <= '0;
            step    <= '0;
            cf      <= 1'b0;
            tens_r  <= '0;
            ones_r  <= '0;
            has_res <= 1'b0;
        end else if (capture) begin
            val_sh <= {cout, s};
            cf     <= cout;
            bcd    <= '0;
            step   <= '0;
        end else if (state == CONV) begin
            val_sh <= {val_sh[3:0], 1'b0};
            bcd    <= bcd_nx;
            step   <= step + 3'd1;
            if (finish) begin
                tens_r  <= bcd_nx[5:4];
                ones_r  <= bcd_nx[3:0];
                has_res <= 1'b1;
            end
        end
    end

    // ---------------- scan ----------------
    // free-running in every state; loads never disturb the scan phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            sel  <= 1'b0;
        end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            sel  <= ~sel;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // ---------------- output stage ----------------
    // Old digits stay visible during a conversion; before the first result
    // (BLANK, or the first CONV) the display is dark.
    always_comb begin
        seg_nx = 7'b1111111;
        an_nx  = 2'b11;
        dp_nx  = 1'b1;
        if (state != BLANK && has_res) begin
            if (!sel) begin
                an_nx  = 2'b10;
                seg_nx = seg_code(ones_r);
                dp_nx  = ~cf;
            end else if (tens_r != 2'd0) begin
                an_nx  = 2'b01;
                seg_nx = seg_code({2'b00, tens_r});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 7'b1111111;
            an  <= 2'b11;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nx;
            an  <= an_nx;
            dp  <= dp_nx;
        end
    end

endmodule

// File: tb/tb_sum_seg_display.sv
module tb_sum_seg_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] s = '0;
    logic       cout = 1'b0;
    logic       load = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;

    int n_tests = 0;
    int n_fail  = 0;

    sum_seg_display #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .cout (cout),
        .load (load),
        .busy (busy),
        .seg  (seg),
        .dp   (dp),
        .an   (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Event-level view: m_n counts edges since reset; a load accepted at edge
    // k lands in the display at edge k+5 and is visible from edge k+6; the
    // digit phase is floor(edge/DIV) mod 2.
    int         m_n, m_last, m_pend, m_disp;
    bit         m_has, m_cf;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_dp, exp_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_last = -100; m_pend = 0; m_disp = 0; m_has = 0; m_cf = 0;
            exp_seg = 7'b1111111; exp_an = 2'b11; exp_dp = 1'b1; exp_busy = 1'b0;
        end else begin
            m_n = m_n + 1;
            exp_seg = 7'b1111111; exp_an = 2'b11; exp_dp = 1'b1;
            if (m_has) begin
                if (((m_n - 1) / DIV) % 2 == 0) begin
                    exp_an = 2'b10; exp_seg = code(m_disp % 10); exp_dp = ~m_cf;
                end else if (m_disp / 10 != 0) begin
                    exp_an = 2'b01; exp_seg = code(m_disp / 10);
                end
            end
            if (m_n == m_last + 5) begin
                m_disp = m_pend; m_has = 1;
            end
            if (load && !(m_n - m_last >= 1 && m_n - m_last <= 5)) begin
                m_last = m_n; m_pend = {cout, s}; m_cf = cout;
            end
            exp_busy = (m_n - m_last) <= 4;
        end
    end

    // stimulus helper: call at a negedge, returns at the negedge after the sampling edge
    task automatic drive_load(input int v);
        s = v[3:0]; cout = v[4]; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (seg !== 7'b1111111 || an !== 2'b11 || dp !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_state seg=%b an=%b dp=%b busy=%b want 1111111 11 1 0", seg, an, dp, busy);
        end
        rst = 1'b0;
        drive_load(5'd12);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (seg !== 7'b1111111 || an !== 2'b11 || dp !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_async seg=%b an=%b dp=%b busy=%b want 1111111 11 1 0", seg, an, dp, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (an !== 2'b11 || seg !== 7'b1111111 || dp !== 1'b1) begin
                n_fail++; $display("FAIL reset_dark cyc=%0d an=%b seg=%b dp=%b want 11 1111111 1", i, an, seg, dp);
            end
        end
    endtask

    task automatic test_five();
        drive_load(5);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (busy !== (i < 5)) begin
                n_fail++; $display("FAIL five_busy cyc=%0d got=%b want=%b", i, busy, (i < 5));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4 * DIV; i++) begin
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || dp !== exp_dp || busy !== exp_busy) begin
                n_fail++; $display("FAIL five_model seg=%b/%b an=%b/%b dp=%b/%b busy=%b/%b", seg, exp_seg, an, exp_an, dp, exp_dp, busy, exp_busy);
            end
            n_tests++;
            if (an === 2'b10) begin
                if (seg !== 7'b0010010 || dp !== 1'b1) begin
                    n_fail++; $display("FAIL five_ones seg=%b dp=%b want 0010010 1", seg, dp);
                end
            end else if (an !== 2'b11 || seg !== 7'b1111111) begin
                n_fail++; $display("FAIL five_tens_blank an=%b seg=%b want 11 1111111", an, seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_max();
        drive_load(31);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4 * DIV; i++) begin
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || dp !== exp_dp || busy !== exp_busy) begin
                n_fail++; $display("FAIL max_model seg=%b/%b an=%b/%b dp=%b/%b busy=%b/%b", seg, exp_seg, an, exp_an, dp, exp_dp, busy, exp_busy);
            end
            n_tests++;
            if (an === 2'b10) begin
                if (seg !== 7'b1111001 || dp !== 1'b0) begin
                    n_fail++; $display("FAIL max_ones seg=%b dp=%b want 1111001 0", seg, dp);
                end
            end else if (an !== 2'b01 || seg !== 7'b0110000 || dp !== 1'b1) begin
                n_fail++; $display("FAIL max_tens an=%b seg=%b dp=%b want 01 0110000 1", an, seg, dp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_during_conv();
        int  rises = 0;
        bit  saw_tens = 0, saw_ones = 0;
        logic prev = busy;
        drive_load(10);
        if (busy && !prev) rises++;
        prev = busy;
        @(negedge clk);
        if (busy && !prev) rises++;
        prev = busy;
        drive_load(3);
        for (int i = 0; i < 6 * DIV; i++) begin
            if (busy && !prev) rises++;
            prev = busy;
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || dp !== exp_dp || busy !== exp_busy) begin
                n_fail++; $display("FAIL ign_model seg=%b/%b an=%b/%b dp=%b/%b busy=%b/%b", seg, exp_seg, an, exp_an, dp, exp_dp, busy, exp_busy);
            end
            if (i >= 6) begin
                if (an === 2'b01 && seg === 7'b1111001) saw_tens = 1;
                if (an === 2'b10 && seg === 7'b1000000) saw_ones = 1;
            end
            @(negedge clk);
        end
        n_tests++;
        if (rises !== 1) begin
            n_fail++; $display("FAIL ign_busy_rises got=%0d want=1", rises);
        end
        n_tests++;
        if (!(saw_tens && saw_ones)) begin
            n_fail++; $display("FAIL ign_digits saw_tens=%0d saw_ones=%0d want 1 1", saw_tens, saw_ones);
        end
    endtask

    task automatic test_abort();
        drive_load(31);
        repeat (8) @(negedge clk);
        drive_load(7);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (seg !== 7'b1111111 || an !== 2'b11 || dp !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_dark seg=%b an=%b dp=%b busy=%b want 1111111 11 1 0", seg, an, dp, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (an !== 2'b11 || seg !== 7'b1111111) begin
                n_fail++; $display("FAIL abort_stays_dark an=%b seg=%b want 11 1111111", an, seg);
            end
        end
        drive_load(7);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4 * DIV; i++) begin
            n_tests++;
            if (an === 2'b10) begin
                if (seg !== 7'b1111000 || dp !== 1'b1) begin
                    n_fail++; $display("FAIL abort_reload_ones seg=%b dp=%b want 1111000 1", seg, dp);
                end
            end else if (an !== 2'b11 || seg !== 7'b1111111) begin
                n_fail++; $display("FAIL abort_reload_tens an=%b seg=%b want 11 1111111", an, seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit saw_new = 0;
        drive_load(22);                 // sampled at edge k
        repeat (4) @(negedge clk);      // now before edge k+5
        s = 4'd9; cout = 1'b0; load = 1'b1;     // edge k+5: ignored
        @(negedge clk);
        s = 4'd4; cout = 1'b1;                  // edge k+6: value 20, accepted
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 5 * DIV; i++) begin
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || dp !== exp_dp || busy !== exp_busy) begin
                n_fail++; $display("FAIL b2b_model seg=%b/%b an=%b/%b dp=%b/%b busy=%b/%b", seg, exp_seg, an, exp_an, dp, exp_dp, busy, exp_busy);
            end
            if (an === 2'b01 && seg === 7'b0100100) saw_new = 1;
            n_tests++;
            if (an === 2'b10 && seg === 7'b0010000) begin
                n_fail++; $display("FAIL b2b_ignored_shown seg=%b (digit 9 should never show)", seg);
            end
            @(negedge clk);
        end
        n_tests++;
        if (!saw_new) begin
            n_fail++; $display("FAIL b2b_new_tens saw=%0d want=1", saw_new);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 5) == 0);
            s    = 4'($urandom);
            cout = 1'($urandom);
            @(negedge clk);
            n_tests++;
            if (seg !== exp_seg || an !== exp_an || dp !== exp_dp || busy !== exp_busy) begin
                n_fail++; $display("FAIL rand_model cyc=%0d seg=%b/%b an=%b/%b dp=%b/%b busy=%b/%b", i, seg, exp_seg, an, exp_an, dp, exp_dp, busy, exp_busy);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_five();
        test_max();
        test_ignore_during_conv();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
